// File: rtl/clock_core_hms_if.sv
// Setting bus between the setting logic and the timekeeping core.
// Carries the mode, the load value and the per-field load enables.
interface clock_core_hms_if;
   logic [1:0] state;
   logic [5:0] num;
   logic       sec_enable;
   logic       min_enable;
   logic       hour_enable;

   modport master (
      output state, num, sec_enable, min_enable, hour_enable
   );

   modport slave (
      input state, num, sec_enable, min_enable, hour_enable
   );
endinterface

// File: rtl/clock_core_hms.sv
// Hour/minute/second timekeeping core with run, set and hold modes.
// Counts 1 Hz ticks with cascade carries and loads range-checked values.
module clock_core_hms #(
   parameter int SEC_MOD  = 60,
   parameter int MIN_MOD  = 60,
   parameter int HOUR_MOD = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick_1hz,
   clock_core_hms_if.slave        bus,
   output logic [5:0]             sec,
   output logic [5:0]             min,
   output logic [4:0]             hour,
   output logic                   min_carry,
   output logic                   hour_carry,
   output logic                   day_carry,
   output logic                   set_err
);

   localparam logic [5:0] SEC_TOP  = 6'(SEC_MOD - 1);
   localparam logic [5:0] MIN_TOP  = 6'(MIN_MOD - 1);
   localparam logic [4:0] HOUR_TOP = 5'(HOUR_MOD - 1);
   localparam logic [6:0] SEC_LIM  = 7'(SEC_MOD);
   localparam logic [6:0] MIN_LIM  = 7'(MIN_MOD);
   localparam logic [6:0] HOUR_LIM = 7'(HOUR_MOD);

   logic       run_mode;
   logic       set_mode;
   logic [2:0] en_now;
   logic [2:0] en_q;
   logic [2:0] rise;
   logic [2:0] ok;
   logic [2:0] load;
   logic [2:0] bad;
   logic       sec_wrap;
   logic       min_wrap;
   logic       hour_wrap;

   always_comb begin
      run_mode = 1'b0;
      set_mode = 1'b0;
      unique case (bus.state)
         2'b00:        run_mode = 1'b1;
         2'b01, 2'b10: set_mode = 1'b1;
         default:      ;
      endcase
   end

   // Bit order everywhere: {hour, min, sec}
   assign en_now = {bus.hour_enable, bus.min_enable, bus.sec_enable};
   assign rise   = en_now & ~en_q;
   assign ok     = {({1'b0, bus.num} < HOUR_LIM),
                    ({1'b0, bus.num} < MIN_LIM),
                    ({1'b0, bus.num} < SEC_LIM)};
   assign load   = rise & ok & {3{set_mode}};
   assign bad    = rise & ~ok & {3{set_mode}};

   assign sec_wrap  = (sec == SEC_TOP);
   assign min_wrap  = sec_wrap && (min == MIN_TOP);
   assign hour_wrap = min_wrap && (hour == HOUR_TOP);

   always_ff @(posedge clk) begin
      if (rst) begin
         sec        <= '0;
         min        <= '0;
         hour       <= '0;
         min_carry  <= 1'b0;
         hour_carry <= 1'b0;
         day_carry  <= 1'b0;
         set_err    <= 1'b0;
         en_q       <= '0;
      end else begin
         en_q       <= en_now;
         min_carry  <= 1'b0;
         hour_carry <= 1'b0;
         day_carry  <= 1'b0;
         set_err    <= |bad;
         if (run_mode && tick_1hz) begin
            sec        <= sec_wrap ? '0 : sec + 6'd1;
            min_carry  <= sec_wrap;
            hour_carry <= min_wrap;
            day_carry  <= hour_wrap;
            if (sec_wrap)
               min <= (min == MIN_TOP) ? '0 : min + 6'd1;
            if (min_wrap)
               hour <= hour_wrap ? '0 : hour + 5'd1;
         end else begin
            if (load[0]) sec  <= bus.num;
            if (load[1]) min  <= bus.num;
            if (load[2]) hour <= bus.num[4:0];
         end
      end
   end

endmodule

// File: tb/tb_clock_core_hms.sv
// Directed bench for clock_core_hms: run, set, hold, carries and reset.
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_clock_core_hms;
   logic       clk = 1'b0;
   logic       rst;
   logic       tick_1hz;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       min_carry;
   logic       hour_carry;
   logic       day_carry;
   logic       set_err;
   int         checks = 0;
   int         errors = 0;

   clock_core_hms_if bus ();

   clock_core_hms dut (
      .clk        (clk),
      .rst        (rst),
      .tick_1hz   (tick_1hz),
      .bus        (bus),
      .sec        (sec),
      .min        (min),
      .hour       (hour),
      .min_carry  (min_carry),
      .hour_carry (hour_carry),
      .day_carry  (day_carry),
      .set_err    (set_err)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m,
                           input int s);
      chk({tag, "_hour"}, 32'(hour), 32'(h));
      chk({tag, "_min"}, 32'(min), 32'(m));
      chk({tag, "_sec"}, 32'(sec), 32'(s));
   endtask

   task automatic chk_pulses(input string tag, input logic mc,
                             input logic hc, input logic dc,
                             input logic se);
      chk({tag, "_pulses"},
          {28'd0, min_carry, hour_carry, day_carry, set_err},
          {28'd0, mc, hc, dc, se});
   endtask

   initial begin
      rst             = 1'b1;
      tick_1hz        = 1'b1;
      bus.state       = 2'b00;
      bus.num         = 6'd0;
      bus.sec_enable  = 1'b0;
      bus.min_enable  = 1'b0;
      bus.hour_enable = 1'b0;
      cyc();
      cyc();
      chk_time("reset", 0, 0, 0);
      chk_pulses("reset", 0, 0, 0, 0);

      // Five back-to-back ticks
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk("run_sec", 32'(sec), 32'(i));
         chk_pulses("run", 0, 0, 0, 0);
      end
      tick_1hz = 1'b0;
      cyc();
      chk_time("run5", 0, 0, 5);

      // Load 23:59:58
      bus.state = 2'b01;
      bus.num = 6'd23; bus.hour_enable = 1'b1; cyc();
      bus.hour_enable = 1'b0;
      bus.num = 6'd59; bus.min_enable = 1'b1; cyc();
      bus.min_enable = 1'b0;
      bus.num = 6'd58; bus.sec_enable = 1'b1; cyc();
      bus.sec_enable = 1'b0;
      chk_time("load", 23, 59, 58);
      chk_pulses("load", 0, 0, 0, 0);

      bus.state = 2'b00;
      tick_1hz = 1'b1;
      cyc();
      chk_time("t59", 23, 59, 59);
      chk_pulses("t59", 0, 0, 0, 0);
      cyc();
      chk_time("wrap", 0, 0, 0);
      chk_pulses("wrap", 1, 1, 1, 0);
      tick_1hz = 1'b0;
      cyc();
      chk_pulses("wrap_end", 0, 0, 0, 0);

      // Out-of-range loads
      bus.state = 2'b01;
      bus.num = 6'd60; bus.sec_enable = 1'b1; cyc();
      chk("sec60", 32'(sec), 32'd0);
      chk_pulses("sec60", 0, 0, 0, 1);
      bus.sec_enable = 1'b0; cyc();
      chk_pulses("sec60_end", 0, 0, 0, 0);
      bus.num = 6'd24; bus.hour_enable = 1'b1; cyc();
      chk("hour24", 32'(hour), 32'd0);
      chk_pulses("hour24", 0, 0, 0, 1);
      bus.hour_enable = 1'b0; bus.num = 6'd23; cyc();
      chk("no_edge", 32'(hour), 32'd0);
      bus.hour_enable = 1'b1; cyc();
      chk("hour23", 32'(hour), 32'd23);
      chk_pulses("hour23", 0, 0, 0, 0);
      bus.hour_enable = 1'b0;
      bus.num = 6'd60; bus.min_enable = 1'b1; cyc();
      chk("min60", 32'(min), 32'd0);
      chk_pulses("min60", 0, 0, 0, 1);
      bus.min_enable = 1'b0;

      // Held enable loads once; ticks ignored in SET
      bus.state = 2'b10;
      bus.num = 6'd10; bus.sec_enable = 1'b1; cyc();
      chk("held_first", 32'(sec), 32'd10);
      tick_1hz = 1'b1;
      for (int n = 11; n <= 20; n++) begin
         bus.num = 6'(n);
         cyc();
      end
      chk_time("held", 23, 0, 10);
      chk_pulses("held", 0, 0, 0, 0);
      tick_1hz = 1'b0;

      // Enable already high on entry to SET does not load
      bus.state = 2'b00; bus.num = 6'd40; cyc();
      bus.state = 2'b01; cyc();
      chk("entry_high", 32'(sec), 32'd10);
      bus.sec_enable = 1'b0;

      // HOLD freezes everything
      bus.state = 2'b11; bus.num = 6'd5; tick_1hz = 1'b1;
      bus.sec_enable = 1'b1; cyc();
      bus.sec_enable = 1'b0; cyc();
      bus.min_enable = 1'b1; cyc();
      chk_time("hold", 23, 0, 10);
      chk_pulses("hold", 0, 0, 0, 0);
      bus.min_enable = 1'b0; tick_1hz = 1'b0; cyc();
      bus.state = 2'b00; tick_1hz = 1'b1; cyc();
      tick_1hz = 1'b0;
      chk_time("resume", 23, 0, 11);

      // Simultaneous loads
      bus.state = 2'b01; bus.num = 6'd30;
      bus.sec_enable = 1'b1; bus.min_enable = 1'b1; cyc();
      chk_time("dual", 23, 30, 30);
      chk_pulses("dual", 0, 0, 0, 0);
      bus.sec_enable = 1'b0; bus.min_enable = 1'b0; cyc();
      bus.num = 6'd45;
      bus.sec_enable = 1'b1; bus.min_enable = 1'b1;
      bus.hour_enable = 1'b1; cyc();
      chk_time("triple", 23, 45, 45);
      chk_pulses("triple", 0, 0, 0, 1);
      cyc();
      chk_pulses("triple_end", 0, 0, 0, 0);
      bus.sec_enable = 1'b0; bus.min_enable = 1'b0;
      bus.hour_enable = 1'b0;

      // Reset mid-count, with a tick pending
      bus.state = 2'b00; tick_1hz = 1'b1; cyc();
      chk("pre_rst", 32'(sec), 32'd46);
      rst = 1'b1; cyc();
      chk_time("mid_rst", 0, 0, 0);
      chk_pulses("mid_rst", 0, 0, 0, 0);
      tick_1hz = 1'b0;

      // Enables held through reset load once afterwards
      bus.state = 2'b01; bus.num = 6'd7;
      bus.sec_enable = 1'b1; bus.min_enable = 1'b1;
      bus.hour_enable = 1'b1; cyc();
      chk_time("rst_held", 0, 0, 0);
      rst = 1'b0; cyc();
      chk_time("post_rst", 7, 7, 7);
      cyc();
      chk_pulses("post_rst", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
